// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 host transmitter.
// The controller supplies a byte and start pulse; the transmitter reports status.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       ack_error;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  done,
        input  ack_error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output done,
        output ack_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked
// frame shift-out, ACK sampling and timeout, driving both lines open-drain.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_host_tx_if.slave  cmd,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, WAIT_ACK, WAIT_IDLE, DONE
    } state_t;

    localparam logic [13:0] INH_LAST = 14'(INHIBIT_CYCLES - 1);
    localparam logic [13:0] RTS_LAST = 14'(RTS_CYCLES - 1);
    localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  clk_sync, data_sync;
    logic        clk_prev;
    logic        sync_clk, sync_data, fall;
    logic [13:0] phase, phase_n;
    logic [20:0] to_cnt, to_n;
    logic [3:0]  bit_cnt, bit_n;
    logic [9:0]  frame, frame_n;
    logic        err, err_n;
    logic        sdata, sdata_n;
    logic        ack_q, ack_n;
    logic        busy_q, done_q;
    logic        clk_oe_n, data_oe_n;
    logic        timeout;

    assign sync_clk  = clk_sync[1];
    assign sync_data = data_sync[1];
    assign fall      = clk_prev & ~sync_clk;
    assign timeout   = (to_cnt == TO_LAST);

    assign cmd.busy      = busy_q;
    assign cmd.done      = done_q;
    assign cmd.ack_error = ack_q;

    // Pin synchronizers; idle bus level is high, so reset them high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= sync_clk;
        end
    end

    // State, counters and registered outputs; reset releases both lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            err         <= 1'b0;
            sdata       <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            to_cnt      <= to_n;
            bit_cnt     <= bit_n;
            frame       <= frame_n;
            err         <= err_n;
            sdata       <= sdata_n;
            ack_q       <= ack_n;
            busy_q      <= (state_n != IDLE) && (state_n != DONE);
            done_q      <= (state_n == DONE);
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
        end
    end

    // Next-state and next-output logic; an edge beats a same-cycle timeout.
    always_comb begin
        state_n = state;
        phase_n = phase;
        to_n    = to_cnt;
        bit_n   = bit_cnt;
        frame_n = frame;
        err_n   = err;
        sdata_n = sdata;
        ack_n   = ack_q;
        unique case (state)
            IDLE: begin
                if (cmd.tx_start) begin
                    frame_n = {1'b1, ~^cmd.tx_data, cmd.tx_data};
                    err_n   = 1'b0;
                    ack_n   = 1'b0;
                    phase_n = '0;
                    to_n    = '0;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (phase == INH_LAST) begin
                    phase_n = '0;
                    state_n = RTS;
                end else begin
                    phase_n = phase + 14'd1;
                end
            end
            RTS: begin
                if (phase == RTS_LAST) begin
                    phase_n = '0;
                    bit_n   = '0;
                    to_n    = '0;
                    sdata_n = 1'b1;
                    state_n = SEND;
                end else begin
                    phase_n = phase + 14'd1;
                end
            end
            SEND: begin
                if (fall) begin
                    to_n    = '0;
                    sdata_n = ~frame[0];
                    frame_n = {1'b0, frame[9:1]};
                    bit_n   = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) state_n = WAIT_ACK;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    to_n = to_cnt + 21'd1;
                end
            end
            WAIT_ACK: begin
                if (fall) begin
                    to_n    = '0;
                    err_n   = sync_data;
                    state_n = WAIT_IDLE;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    to_n = to_cnt + 21'd1;
                end
            end
            WAIT_IDLE: begin
                if (sync_clk && sync_data) begin
                    state_n = DONE;
                end else if (fall) begin
                    to_n = '0;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    to_n = to_cnt + 21'd1;
                end
            end
            DONE: begin
                to_n    = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state_n == DONE) ack_n = err_n;
        clk_oe_n  = (state_n == INHIBIT) || (state_n == RTS);
        data_oe_n = (state_n == RTS) || ((state_n == SEND) && sdata_n);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out,
// a scoreboard holds expected frames and ack_error values per transfer.
module tb_ps2_host_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic line_clk, line_data;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;

    logic [9:0] exp_frame_q[$];
    logic       exp_err_q[$];

    ps2_host_tx_if cmd ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .RTS_CYCLES(5),
        .TIMEOUT_CYCLES(500)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .ps2_clk_in(line_clk),
        .ps2_data_in(line_data),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    assign line_clk  = ~ps2_clk_oe & dev_clk;
    assign line_data = ~ps2_data_oe & dev_data;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Done monitor: each pulse consumes one expected ack_error.
    always @(negedge clk) begin
        if (prev_done) chk("busy_after_done", {31'd0, cmd.busy}, 32'd0);
        if (cmd.done === 1'b1) begin
            done_cnt++;
            if (exp_err_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                chk("ack_error", {31'd0, cmd.ack_error},
                    {31'd0, exp_err_q.pop_front()});
            end
        end
        prev_done = cmd.done;
    end

    function automatic logic [9:0] mk_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic send_cmd(input logic [7:0] d, input logic e);
        int n;
        exp_frame_q.push_back(mk_frame(d));
        exp_err_q.push_back(e);
        cmd.tx_data  = d;
        cmd.tx_start = 1'b1;
        tick(1);
        cmd.tx_start = 1'b0;
        chk("busy_on_accept", {31'd0, cmd.busy}, 32'd1);
        chk("ack_err_cleared", {31'd0, cmd.ack_error}, 32'd0);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
            n++;
            tick(1);
        end
        chk("inhibit_len", n, 20);
        n = 0;
        while (ps2_clk_oe && ps2_data_oe && n < 100) begin
            n++;
            tick(1);
        end
        chk("rts_len", n, 5);
        chk("clk_released", {31'd0, ps2_clk_oe}, 32'd0);
    endtask

    task automatic device(input logic ack, input logic inj,
                          input int edges);
        logic [9:0] got = '0;
        logic [9:0] exp = exp_frame_q.pop_front();
        tick(10);
        chk("start_bit", {31'd0, line_data}, 32'd0);
        for (int i = 0; i < edges; i++) begin
            if (i == 10) dev_data = ack ? 1'b0 : 1'b1;
            if (inj && i == 3) begin
                cmd.tx_data  = 8'hAA;
                cmd.tx_start = 1'b1;
            end
            tick(1);
            cmd.tx_start = 1'b0;
            tick(4);
            dev_clk = 1'b0;
            tick(20);
            if (i < 10) got[i] = line_data;
            dev_clk = 1'b1;
            if (i == 10) dev_data = 1'b1;
            tick(15);
        end
        if (edges == 11) chk("frame_bits", {22'd0, got}, {22'd0, exp});
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            n++;
            tick(1);
        end
        chk("done_seen", done_cnt, target);
        tick(5);
        chk("done_once", done_cnt, target);
        chk("idle_busy", {31'd0, cmd.busy}, 32'd0);
    endtask

    initial begin
        int n;
        cmd.tx_data  = 8'h00;
        cmd.tx_start = 1'b0;
        tick(3);
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("rst_busy", {31'd0, cmd.busy}, 32'd0);
        chk("rst_done", {31'd0, cmd.done}, 32'd0);
        chk("rst_ack_err", {31'd0, cmd.ack_error}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        send_cmd(8'hED, 1'b0);
        device(1'b1, 1'b0, 11);
        wait_done(1);

        send_cmd(8'hF4, 1'b0);
        device(1'b1, 1'b0, 11);
        wait_done(2);

        send_cmd(8'h00, 1'b1);
        device(1'b0, 1'b0, 11);
        wait_done(3);
        chk("ack_err_held", {31'd0, cmd.ack_error}, 32'd1);

        send_cmd(8'hED, 1'b0);
        device(1'b1, 1'b1, 11);
        wait_done(4);

        send_cmd(8'h55, 1'b1);
        void'(exp_frame_q.pop_front());
        n = 0;
        while (cmd.done !== 1'b1 && n < 1000) begin
            n++;
            tick(1);
        end
        chk("timeout_len", n, 500);
        chk("to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        wait_done(5);

        send_cmd(8'hF4, 1'b0);
        device(1'b1, 1'b0, 4);
        chk("pre_rst_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("arst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("arst_busy", {31'd0, cmd.busy}, 32'd0);
        void'(exp_err_q.pop_back());
        tick(4);
        rst_n = 1'b1;
        tick(4);
        chk("arst_no_done", done_cnt, 5);

        send_cmd(8'hED, 1'b0);
        device(1'b1, 1'b0, 11);
        wait_done(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
